// File: rtl/instr_fetch.sv
// Instruction fetch stage: reads opcode, arg1 and arg2 from byte-wide program memory
// at pc, pc+1 and pc+2, and presents them to the core as one qualified instruction.
module instr_fetch #(
   parameter int          ADDR_W     = 16,
   parameter logic [7:0]  NOP_OPCODE = 8'h00
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [7:0]        mem_rdata,
   output logic [7:0]        op_code,
   output logic [7:0]        arg1,
   output logic [7:0]        arg2,
   output logic              instr_valid
);

   typedef enum logic [2:0] {IDLE, F0, F1, F2, F3, VALID} state_t;

   state_t            state_q, state_d;
   logic              haveInstr_q, haveInstr_d;
   logic [ADDR_W-1:0] fetchPc_q, fetchPc_d;
   logic [ADDR_W-1:0] memAddr_q, memAddr_d;
   logic              memRd_q, memRd_d;
   logic [7:0]        opByte_q, opByte_d;
   logic [7:0]        arg1Byte_q, arg1Byte_d;
   logic [7:0]        opCode_q, opCode_d;
   logic [7:0]        arg1Out_q, arg1Out_d;
   logic [7:0]        arg2Out_q, arg2Out_d;
   logic              valid_q, valid_d;
   logic              startFetch;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         haveInstr_q <= 1'b0;
         fetchPc_q   <= '0;
         memAddr_q   <= '0;
         memRd_q     <= 1'b0;
         opByte_q    <= NOP_OPCODE;
         arg1Byte_q  <= NOP_OPCODE;
         opCode_q    <= NOP_OPCODE;
         arg1Out_q   <= NOP_OPCODE;
         arg2Out_q   <= NOP_OPCODE;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         haveInstr_q <= haveInstr_d;
         fetchPc_q   <= fetchPc_d;
         memAddr_q   <= memAddr_d;
         memRd_q     <= memRd_d;
         opByte_q    <= opByte_d;
         arg1Byte_q  <= arg1Byte_d;
         opCode_q    <= opCode_d;
         arg1Out_q   <= arg1Out_d;
         arg2Out_q   <= arg2Out_d;
         valid_q     <= valid_d;
      end
   end

   // A pc change restarts the fetch from any state; the forced first fetch only
   // applies from IDLE, otherwise it would keep restarting its own fetch.
   assign startFetch = (pc != fetchPc_q) || ((state_q == IDLE) && !haveInstr_q);

   always_comb begin
      state_d     = state_q;
      haveInstr_d = haveInstr_q;
      fetchPc_d   = fetchPc_q;
      memAddr_d   = memAddr_q;
      memRd_d     = memRd_q;
      opByte_d    = opByte_q;
      arg1Byte_d  = arg1Byte_q;
      opCode_d    = opCode_q;
      arg1Out_d   = arg1Out_q;
      arg2Out_d   = arg2Out_q;
      valid_d     = valid_q;

      case (state_q)
         F0: begin
            memAddr_d = fetchPc_q + ADDR_W'(1);
            state_d   = F1;
         end
         F1: begin
            opByte_d  = mem_rdata;
            memAddr_d = fetchPc_q + ADDR_W'(2);
            state_d   = F2;
         end
         F2: begin
            arg1Byte_d = mem_rdata;
            memRd_d    = 1'b0;
            state_d    = F3;
         end
         F3: begin
            opCode_d    = opByte_q;
            arg1Out_d   = arg1Byte_q;
            arg2Out_d   = mem_rdata;
            valid_d     = 1'b1;
            haveInstr_d = 1'b1;
            state_d     = VALID;
         end
         default: ;
      endcase

      // Restart overrides normal progress so partial bytes never reach the outputs
      if (startFetch) begin
         fetchPc_d  = pc;
         memAddr_d  = pc;
         memRd_d    = 1'b1;
         valid_d    = 1'b0;
         opByte_d   = NOP_OPCODE;
         arg1Byte_d = NOP_OPCODE;
         opCode_d   = NOP_OPCODE;
         arg1Out_d  = NOP_OPCODE;
         arg2Out_d  = NOP_OPCODE;
         state_d    = F0;
      end
   end

   assign mem_addr    = memAddr_q;
   assign mem_rd      = memRd_q;
   assign op_code     = opCode_q;
   assign arg1        = arg1Out_q;
   assign arg2        = arg2Out_q;
   assign instr_valid = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: byte memory model, pc-history reference model checked every
// cycle, and directed scenarios with hand-computed literal expectations.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] pc;
   logic [15:0] mem_addr;
   logic        mem_rd;
   logic [7:0]  mem_rdata = 8'h00;
   logic [7:0]  op_code, arg1, arg2;
   logic        instr_valid;

   int checks   = 0;
   int failures = 0;

   logic [7:0] mem [0:65535];

   instr_fetch #(.ADDR_W(16), .NOP_OPCODE(8'h00)) dut (
      .clk(clk), .rst_n(rst_n), .pc(pc),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
      .op_code(op_code), .arg1(arg1), .arg2(arg2), .instr_valid(instr_valid)
   );

   always #5 clk = ~clk;

   // Read data appears one cycle after the strobe; junk otherwise to expose misuse
   always @(posedge clk) begin
      mem_rdata <= mem_rd ? mem[mem_addr] : 8'h5A;
   end

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the instruction for pc is valid once the same pc has been
   // sampled on five consecutive edges since reset; reads happen on the first three.
   int          run = 0;
   logic [15:0] lastPc = 16'h0000;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run <= 0;
      end else if (run != 0 && pc == lastPc) begin
         run <= (run < 1000) ? run + 1 : run;
      end else begin
         run    <= 1;
         lastPc <= pc;
      end
   end

   logic        expValid, expRd;
   logic [15:0] expAddr, pc1, pc2;
   logic [7:0]  expOp, expA1, expA2;

   always @(negedge clk) begin
      pc1      = lastPc + 16'd1;
      pc2      = lastPc + 16'd2;
      expValid = (run >= 5);
      expRd    = (run >= 1) && (run <= 3);
      expAddr  = (run == 0) ? 16'h0000 : lastPc + 16'(run - 1);
      expOp    = expValid ? mem[lastPc] : 8'h00;
      expA1    = expValid ? mem[pc1]    : 8'h00;
      expA2    = expValid ? mem[pc2]    : 8'h00;
      checkOutput("model_valid", {15'd0, instr_valid}, {15'd0, expValid});
      checkOutput("model_rd",    {15'd0, mem_rd},      {15'd0, expRd});
      checkOutput("model_op",    {8'd0, op_code},      {8'd0, expOp});
      checkOutput("model_arg1",  {8'd0, arg1},         {8'd0, expA1});
      checkOutput("model_arg2",  {8'd0, arg2},         {8'd0, expA2});
      if (run <= 3) checkOutput("model_addr", mem_addr, expAddr);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic applyStimulus(input logic [15:0] newPc);
      pc = newPc;
   endtask

   task automatic checkInstr(input string name, input logic [7:0] o, input logic [7:0] a, input logic [7:0] b);
      checkOutput({name, "_valid"}, {15'd0, instr_valid}, 16'h0001);
      checkOutput({name, "_op"},    {8'd0, op_code}, {8'd0, o});
      checkOutput({name, "_arg1"},  {8'd0, arg1},    {8'd0, a});
      checkOutput({name, "_arg2"},  {8'd0, arg2},    {8'd0, b});
   endtask

   initial begin
      int rdCount;
      for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3);
      mem[16'h0000] = 8'h10; mem[16'h0001] = 8'h05; mem[16'h0002] = 8'h07;
      mem[16'h0003] = 8'hA1; mem[16'h0004] = 8'hB2; mem[16'h0005] = 8'hC3;
      mem[16'h0006] = 8'h61; mem[16'h0007] = 8'h62; mem[16'h0008] = 8'h63;
      mem[16'h0010] = 8'hD1; mem[16'h0011] = 8'hD2; mem[16'h0012] = 8'hD3;
      mem[16'hFFFF] = 8'hF9;

      rst_n = 1'b0;
      pc    = 16'h0000;
      tick(2);
      checkOutput("rst_valid", {15'd0, instr_valid}, 16'h0000);
      checkOutput("rst_rd",    {15'd0, mem_rd},      16'h0000);
      checkOutput("rst_addr",  mem_addr,             16'h0000);
      checkOutput("rst_op",    {8'd0, op_code},      16'h0000);

      // First fetch forced at pc=0
      rst_n = 1'b1;
      tick(1);
      checkOutput("t1_rd0",   {15'd0, mem_rd}, 16'h0001);
      checkOutput("t1_addr0", mem_addr, 16'h0000);
      tick(1);
      checkOutput("t1_addr1", mem_addr, 16'h0001);
      tick(1);
      checkOutput("t1_addr2", mem_addr, 16'h0002);
      checkOutput("t1_rd2",   {15'd0, mem_rd}, 16'h0001);
      tick(1);
      checkOutput("t1_rd3",   {15'd0, mem_rd}, 16'h0000);
      checkOutput("t1_notyet", {15'd0, instr_valid}, 16'h0000);
      tick(1);
      checkInstr("t1", 8'h10, 8'h05, 8'h07);

      // Steady pc: no memory traffic
      rdCount = 0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (mem_rd) rdCount++;
      end
      checkOutput("t2_rdcount", 16'(rdCount), 16'h0000);
      checkInstr("t2", 8'h10, 8'h05, 8'h07);

      // pc change refetches
      applyStimulus(16'h0003);
      tick(1);
      checkOutput("t3_drop", {15'd0, instr_valid}, 16'h0000);
      checkOutput("t3_nop",  {8'd0, op_code}, 16'h0000);
      tick(4);
      checkInstr("t3", 8'hA1, 8'hB2, 8'hC3);

      // Abort during F1
      applyStimulus(16'h0006);
      tick(2);
      applyStimulus(16'h0010);
      tick(1);
      checkOutput("t4_restart", mem_addr, 16'h0010);
      tick(3);
      checkOutput("t4_notyet", {15'd0, instr_valid}, 16'h0000);
      tick(1);
      checkInstr("t4", 8'hD1, 8'hD2, 8'hD3);

      // Address wrap
      applyStimulus(16'hFFFF);
      tick(1);
      checkOutput("t5_addr0", mem_addr, 16'hFFFF);
      tick(1);
      checkOutput("t5_addr1", mem_addr, 16'h0000);
      tick(1);
      checkOutput("t5_addr2", mem_addr, 16'h0001);
      tick(2);
      checkInstr("t5", 8'hF9, 8'h10, 8'h05);

      // Reset asserted during F2
      applyStimulus(16'h0003);
      tick(3);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("t6_valid", {15'd0, instr_valid}, 16'h0000);
      checkOutput("t6_rd",    {15'd0, mem_rd}, 16'h0000);
      checkOutput("t6_addr",  mem_addr, 16'h0000);
      checkOutput("t6_op",    {8'd0, op_code}, 16'h0000);
      tick(1);
      rst_n = 1'b1;
      tick(1);
      checkOutput("t6_refetch", mem_addr, 16'h0003);
      tick(4);
      checkInstr("t6", 8'hA1, 8'hB2, 8'hC3);

      // Same pc written again is not a change
      applyStimulus(16'h0003);
      tick(5);
      checkInstr("t7", 8'hA1, 8'hB2, 8'hC3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
